// File: rtl/sram_req_ctrl_if.sv
// Request/response stream between an initiator and sram_req_ctrl.
// The master drives requests and consumes responses; the slave is the controller.
interface sram_req_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_req_ctrl.sv
// Initiator-side controller for a single-port SRAM with 1-cycle read latency.
// Read data returns in order through a 2-entry FIFO guarded by a credit check.
module sram_req_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_req_ctrl_if.slave        bus,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic                  sram_wr,
    input  logic [DATA_WIDTH-1:0] sram_qout
);
    logic [DATA_WIDTH-1:0] entry [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  rd_inflight;
    logic                  acc;
    logic                  pop;
    logic                  push;
    logic [2:0]            credit;

    assign acc  = bus.req_valid && bus.req_ready;
    assign pop  = bus.rsp_valid && bus.rsp_ready;
    assign push = rd_inflight;

    // Reads queued plus in flight, minus the one leaving now; pop implies count >= 1.
    assign credit        = {1'b0, count} + {2'b00, rd_inflight} - {2'b00, pop};
    assign bus.req_ready = !rst && (credit < 3'd2);
    assign bus.rsp_valid = !rst && (count != 2'd0);
    assign bus.rsp_rdata = rst ? '0 : entry[rd_ptr];

    assign sram_addr = bus.req_addr;
    assign sram_din  = bus.req_wdata;
    assign sram_wr   = acc && bus.req_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            rd_inflight <= 1'b0;
            // NOTE: storage is reset here only so rsp_rdata reads 0 out of reset.
            entry[0]    <= '0;
            entry[1]    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            rd_inflight <= acc && !bus.req_wr;
            if (push) begin
                entry[wr_ptr] <= sram_qout;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: behavioural SRAM, queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_sram_req_ctrl;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_qout;
    logic          sram_wr;

    sram_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_wr   (sram_wr),
        .sram_qout (sram_qout)
    );

    always #5 clk = ~clk;

    // Behavioural sp_sram: registered output, X after a write cycle.
    logic [DW-1:0] sram_mem [16];
    always @(posedge clk) begin
        if (sram_wr) begin
            sram_mem[sram_addr] <= sram_din;
            sram_qout           <= 'x;
        end else begin
            sram_qout <= sram_mem[sram_addr];
        end
    end

    // Reference model: expected read data in request order, each with the cycle it becomes visible.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          q[$];
    logic [DW-1:0] mdl_mem [16];
    int            cyc;
    int            n_pass;
    int            n_total;

    logic          exp_valid, exp_pop, exp_ready, exp_acc;
    logic [DW-1:0] exp_data;
    logic          obs_valid, obs_ready, obs_wr;
    logic [DW-1:0] obs_data, obs_din;
    logic [AW-1:0] obs_addr;

    task automatic drive(input logic v, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic rr);
        bus.req_valid = v;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = rr;
    endtask

    // Sample outputs mid-cycle, then advance the model across the rising edge.
    task automatic run_cycle();
        @(negedge clk);
        exp_valid = !rst && q.size() != 0 && q[0].due <= cyc;
        exp_data  = exp_valid ? q[0].data : '0;
        exp_pop   = exp_valid && bus.rsp_ready;
        exp_ready = !rst && (q.size() - (exp_pop ? 1 : 0)) < 2;
        exp_acc   = bus.req_valid && exp_ready;
        obs_valid = bus.rsp_valid;
        obs_ready = bus.req_ready;
        obs_data  = bus.rsp_rdata;
        obs_wr    = sram_wr;
        obs_addr  = sram_addr;
        obs_din   = sram_din;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_acc && bus.req_wr) mdl_mem[bus.req_addr] = bus.req_wdata;
            else if (exp_acc) q.push_back('{mdl_mem[bus.req_addr], cyc + 2});
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 4'd2, 16'hDEAD, 1'b1);
        repeat (2) begin
            run_cycle();
            n_total++; if (obs_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", obs_ready); else n_pass++;
            n_total++; if (obs_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", obs_valid); else n_pass++;
            n_total++; if (obs_wr !== 1'b0) $display("FAIL reset_sram_wr got=%b exp=0", obs_wr); else n_pass++;
            n_total++; if (obs_data !== 16'h0) $display("FAIL reset_rsp_rdata got=%h exp=0000", obs_data); else n_pass++;
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
        run_cycle();
        n_total++; if (obs_ready !== 1'b1) $display("FAIL post_reset_req_ready got=%b exp=1", obs_ready); else n_pass++;
        n_total++; if (obs_valid !== 1'b0) $display("FAIL post_reset_rsp_valid got=%b exp=0", obs_valid); else n_pass++;
        n_total++; if (obs_data !== 16'h0) $display("FAIL post_reset_rsp_rdata got=%h exp=0000", obs_data); else n_pass++;
    endtask

    task automatic test_streaming();
        logic [DW-1:0] want;
        for (int i = 0; i < 19; i++) begin
            if (i < 16) drive(1'b1, 1'b0, i[AW-1:0], 16'h0, 1'b1);
            else        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
            run_cycle();
            if (i < 16) begin
                n_total++; if (obs_ready !== 1'b1) $display("FAIL stream_req_ready i=%0d got=%b exp=1", i, obs_ready); else n_pass++;
            end
            if (i >= 2 && i < 18) begin
                want = 16'h100 + 16'(i - 2);
                n_total++; if (obs_valid !== 1'b1 || obs_data !== want)
                    $display("FAIL stream_rsp i=%0d got=%b/%h exp=1/%h", i, obs_valid, obs_data, want); else n_pass++;
            end else begin
                n_total++; if (obs_valid !== 1'b0) $display("FAIL stream_idle i=%0d got=%b exp=0", i, obs_valid); else n_pass++;
            end
        end
    endtask

    task automatic test_write_readback();
        drive(1'b1, 1'b1, 4'd3, 16'h1234, 1'b1);
        run_cycle();
        n_total++; if (obs_wr !== 1'b1) $display("FAIL wr_sram_wr got=%b exp=1", obs_wr); else n_pass++;
        drive(1'b1, 1'b0, 4'd3, 16'h0, 1'b1);
        run_cycle();
        n_total++; if (obs_wr !== 1'b0) $display("FAIL rd_sram_wr got=%b exp=0", obs_wr); else n_pass++;
        n_total++; if (obs_valid !== 1'b0) $display("FAIL wr_no_rsp_n1 got=%b exp=0", obs_valid); else n_pass++;
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
        run_cycle();
        n_total++; if (obs_valid !== 1'b0) $display("FAIL wr_no_rsp_n2 got=%b exp=0", obs_valid); else n_pass++;
        run_cycle();
        n_total++; if (obs_valid !== 1'b1 || obs_data !== 16'h1234)
            $display("FAIL readback got=%b/%h exp=1/1234", obs_valid, obs_data); else n_pass++;
        run_cycle();
        n_total++; if (obs_valid !== 1'b0) $display("FAIL readback_single got=%b exp=0", obs_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        int            sent = 0;
        int            got  = 0;
        logic [DW-1:0] got_data [4];
        for (int c = 0; c < 6; c++) begin
            drive(sent < 4, 1'b0, 4'(8 + sent), 16'h0, 1'b0);
            run_cycle();
            if (bus.req_valid && obs_ready) sent++;
        end
        n_total++; if (sent !== 2) $display("FAIL bp_accepted got=%0d exp=2", sent); else n_pass++;
        n_total++; if (obs_ready !== 1'b0) $display("FAIL bp_req_ready got=%b exp=0", obs_ready); else n_pass++;
        n_total++; if (obs_valid !== 1'b1) $display("FAIL bp_rsp_valid got=%b exp=1", obs_valid); else n_pass++;
        for (int c = 0; c < 12; c++) begin
            drive(sent < 4, 1'b0, 4'(8 + sent), 16'h0, 1'b1);
            run_cycle();
            if (bus.req_valid && obs_ready) sent++;
            if (obs_valid) begin
                if (got < 4) got_data[got] = obs_data;
                got++;
            end
        end
        n_total++; if (got !== 4) $display("FAIL bp_rsp_count got=%0d exp=4", got); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_total++; if (got_data[k] !== 16'h108 + 16'(k))
                $display("FAIL bp_order k=%0d got=%h exp=%h", k, got_data[k], 16'h108 + 16'(k)); else n_pass++;
        end
    endtask

    task automatic test_push_pop();
        logic [DW-1:0] want;
        drive(1'b1, 1'b0, 4'd12, 16'h0, 1'b0);
        run_cycle();
        drive(1'b1, 1'b0, 4'd13, 16'h0, 1'b0);
        run_cycle();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 4'(14 + k), 16'h0, 1'b1);
            run_cycle();
            want = 16'h100 + 16'((12 + k) % 16);
            n_total++; if (obs_valid !== 1'b1 || obs_data !== want)
                $display("FAIL pp_rsp k=%0d got=%b/%h exp=1/%h", k, obs_valid, obs_data, want); else n_pass++;
            n_total++; if (obs_ready !== 1'b1) $display("FAIL pp_req_ready k=%0d got=%b exp=1", k, obs_ready); else n_pass++;
        end
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            if (k < 2) begin
                want = 16'h101 + 16'(k);
                n_total++; if (obs_valid !== 1'b1 || obs_data !== want)
                    $display("FAIL pp_drain k=%0d got=%b/%h exp=1/%h", k, obs_valid, obs_data, want); else n_pass++;
            end else begin
                n_total++; if (obs_valid !== 1'b0) $display("FAIL pp_empty got=%b exp=0", obs_valid); else n_pass++;
            end
        end
    endtask

    task automatic test_interleaved();
        int            got = 0;
        logic [DW-1:0] got_data [2];
        for (int c = 0; c < 10; c++) begin
            case (c)
                0:       drive(1'b1, 1'b1, 4'd5, 16'hAAAA, 1'b1);
                2:       drive(1'b1, 1'b0, 4'd5, 16'h0, 1'b1);
                3:       drive(1'b1, 1'b1, 4'd5, 16'h5555, 1'b1);
                4:       drive(1'b1, 1'b0, 4'd5, 16'h0, 1'b1);
                default: drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
            endcase
            run_cycle();
            if (obs_valid) begin
                n_total++; if ($isunknown(obs_data)) $display("FAIL il_x_data c=%0d got=%h exp=known", c, obs_data); else n_pass++;
                if (got < 2) got_data[got] = obs_data;
                got++;
            end
        end
        n_total++; if (got !== 2) $display("FAIL il_rsp_count got=%0d exp=2", got); else n_pass++;
        n_total++; if (got_data[0] !== 16'hAAAA) $display("FAIL il_first got=%h exp=aaaa", got_data[0]); else n_pass++;
        n_total++; if (got_data[1] !== 16'h5555) $display("FAIL il_second got=%h exp=5555", got_data[1]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 4'd6, 16'h0, 1'b0);
        run_cycle();
        drive(1'b1, 1'b0, 4'd7, 16'h0, 1'b0);
        run_cycle();
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
        run_cycle();
        n_total++; if (obs_valid !== 1'b0) $display("FAIL mid_rst_rsp_valid got=%b exp=0", obs_valid); else n_pass++;
        n_total++; if (obs_ready !== 1'b0) $display("FAIL mid_rst_req_ready got=%b exp=0", obs_ready); else n_pass++;
        n_total++; if (obs_data !== 16'h0) $display("FAIL mid_rst_rsp_rdata got=%h exp=0000", obs_data); else n_pass++;
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'd3, 16'h0, 1'b1);
        run_cycle();
        n_total++; if (obs_ready !== 1'b1) $display("FAIL mid_rst_first_acc got=%b exp=1", obs_ready); else n_pass++;
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            run_cycle();
            if (k == 1) begin
                n_total++; if (obs_valid !== 1'b1 || obs_data !== 16'h1234)
                    $display("FAIL mid_rst_readback got=%b/%h exp=1/1234", obs_valid, obs_data); else n_pass++;
            end else begin
                n_total++; if (obs_valid !== 1'b0) $display("FAIL mid_rst_stale k=%0d got=%b exp=0", k, obs_valid); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 404; c++) begin
            if (c < 400)
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                      16'($urandom), $urandom_range(0, 3) != 0);
            else
                drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
            run_cycle();
            n_total++; if (obs_ready !== exp_ready) $display("FAIL rnd_req_ready c=%0d got=%b exp=%b", c, obs_ready, exp_ready); else n_pass++;
            n_total++; if (obs_valid !== exp_valid) $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, obs_valid, exp_valid); else n_pass++;
            if (exp_valid) begin
                n_total++; if (obs_data !== exp_data) $display("FAIL rnd_rsp_rdata c=%0d got=%h exp=%h", c, obs_data, exp_data); else n_pass++;
            end
            n_total++; if (obs_wr !== (exp_acc && bus.req_wr))
                $display("FAIL rnd_sram_wr c=%0d got=%b exp=%b", c, obs_wr, exp_acc && bus.req_wr); else n_pass++;
            n_total++; if (obs_addr !== bus.req_addr || obs_din !== bus.req_wdata)
                $display("FAIL rnd_sram_pins c=%0d got=%h/%h exp=%h/%h", c, obs_addr, obs_din, bus.req_addr, bus.req_wdata); else n_pass++;
        end
    endtask

    initial begin
        cyc     = 0;
        n_pass  = 0;
        n_total = 0;
        for (int k = 0; k < 16; k++) begin
            sram_mem[k] = 16'h100 + 16'(k);
            mdl_mem[k]  = 16'h100 + 16'(k);
        end
        test_reset();
        test_streaming();
        test_write_readback();
        test_backpressure();
        test_push_pop();
        test_interleaved();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
